logisim_clock_tree_gen: RTL and testbench
=========================================

# logisim_clock_tree_gen

Parametrised multi-channel clock-tree generator for the FPGA top-level shell. It replaces the fixed single-rate tick generator plus single clock component with one block. The block contains a shared prescaler and `NrOfChannels` independent derived clocks, each with runtime-programmable high/low tick counts. It adds run/halt/single-step modes, with single-step driven by a debounced-elsewhere `Go` button, so the MIPS CPU can be clocked per instruction on the board.

## Interface
Parameters:
- `NrOfChannels`, default 2: number of derived clock channels (≥1).
- `NrOfBits`, default 32: prescaler counter width.
- `ReloadValue`, default 200000: FPGA clock cycles per `FPGA_Tick` (≥1, < 2^NrOfBits).
- `TickBits`, default 4: width of each channel's high/low tick count.

Ports:
- `FPGA_GlobalClock`  in  1  sole clock; all state changes on its rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `Go`  in  1  step request; asynchronous to the clock, level input.
- `Mode`  in  2  operating mode: 00 halt, 01 run, 10 step, 11 halt (reserved).
- `HighTicks`  in  NrOfChannels*TickBits  channel i high-phase length in ticks, bits [i*TickBits +: TickBits].
- `LowTicks`  in  NrOfChannels*TickBits  channel i low-phase length in ticks, same packing.
- `ClkOut`  out  NrOfChannels  derived clock level per channel.
- `RiseTick`  out  NrOfChannels  one-cycle pulse when the channel's ClkOut goes 0→1.
- `FallTick`  out  NrOfChannels  one-cycle pulse when the channel's ClkOut goes 1→0.
- `FPGA_Tick`  out  1  prescaler tick, one cycle wide.
- `Busy`  out  1  single step in progress.

## Operation
- Prescaler:
  - Down-counter loaded with ReloadValue-1.
  - Decrements every cycle in every mode.
  - At 0 it asserts `FPGA_Tick` for one cycle and reloads.
- Channel FSM, one per channel:
  - States LOW and HIGH, each with a TickBits counter.
  - An enabled tick with counter≠0 decrements the counter.
  - An enabled tick with counter=0 toggles the phase, pulses RiseTick (LOW→HIGH) or FallTick (HIGH→LOW), and loads the counter with N-1.
  - N is the new phase's High/LowTicks value, sampled at that edge. N=0 is treated as 1.
  - Each phase therefore lasts exactly max(N,1) ticks.
  - Changes to High/LowTicks mid-phase take effect only at the next phase entry.
- Enable, common to all channels:
  - Run: every FPGA_Tick.
  - Halt: none. Counters and ClkOut freeze.
  - Step: FPGA_Tick while Busy=1.
- Go path:
  - Two-flop synchroniser, then a rising-edge detector.
  - A detected edge in step mode with Busy=0 sets Busy.
  - Busy clears on the cycle channel 0 emits FallTick. That tick is included, so one step equals exactly one rising and one falling edge of channel 0.
  - Go edges while Busy=1, or outside step mode, are ignored and not queued.
- Leaving step mode while Busy=1 clears Busy immediately. Channel state freezes or continues per the new mode.
- Simultaneous Go edge and FallTick on channel 0 (Busy=1): Busy clears; the edge is dropped.

## Timing
- Reset values while `RST`=1, applied asynchronously:
  - Prescaler = ReloadValue-1.
  - FPGA_Tick, ClkOut, RiseTick, FallTick, Busy all 0.
  - Phase LOW, channel counters 0, synchroniser flops 0.
- After RST deasserts, the first FPGA_Tick is asserted in cycle ReloadValue. With ReloadValue=1 the tick is high every cycle.
- With counters at 0 after reset, the first enabled tick moves every channel LOW→HIGH.
- Steady-state run period of channel i is (H+L)·ReloadValue cycles, with H=max(HighTicks_i,1) and L=max(LowTicks_i,1).
- All outputs are registered:
  - RiseTick/FallTick change on the same edge as ClkOut and last one cycle.
  - That edge is the edge at which FPGA_Tick is sampled high.
- Go to Busy latency: Busy=1 is visible 3 cycles after Go rises (2 sync flops + edge register).
- RST asserted mid-phase or mid-step forces all outputs to reset values within the same cycle (asynchronous). There is no partial step on release.

## Test plan
- ReloadValue=4, RST released → FPGA_Tick high in cycles 4, 8, 12, …, one cycle wide each; all other outputs 0 until the first tick.
- Run, ReloadValue=4, ch0 H=1 L=1, ch1 H=3 L=1 → ch0 period 8 cycles at 50% duty; ch1 high 12 / low 4 cycles; one RiseTick and one FallTick per period, each coincident with its ClkOut edge.
- Run, ch0 HighTicks=0 LowTicks=0 → identical to H=1 L=1. Change ch1 H from 3 to 1 mid-HIGH → the current high phase still lasts 3 ticks; the next high phase lasts 1 tick.
- Step mode, Go pulse of 10 cycles → Busy rises 3 cycles later; exactly one RiseTick and one FallTick on ch0; Busy falls with FallTick; ClkOut then stays 0. A second Go rise while Busy=1 produces no extra edges.
- Run, switch to halt in the middle of ch0 HIGH, hold 100 cycles, return to run → ClkOut stays 1 with no ticks during halt; the remaining high ticks complete after resume.
- RST pulsed in the middle of a step → ClkOut, Busy, and ticks go 0 immediately; after release, Busy stays 0 until a new Go edge.

Source files
------------

// File: rtl/logisim_clock_tree_gen.sv
// Multi-channel clock-tree generator: shared prescaler plus
// per-channel high/low tick clocks with run/halt/single-step.
module logisim_clock_tree_gen #(
  parameter int NrOfChannels = 2,
  parameter int NrOfBits     = 32,
  parameter int ReloadValue  = 200000,
  parameter int TickBits     = 4
) (
  input  logic                             FPGA_GlobalClock,
  input  logic                             RST,
  input  logic                             Go,
  input  logic [1:0]                       Mode,
  input  logic [NrOfChannels*TickBits-1:0] HighTicks,
  input  logic [NrOfChannels*TickBits-1:0] LowTicks,
  output logic [NrOfChannels-1:0]          ClkOut,
  output logic [NrOfChannels-1:0]          RiseTick,
  output logic [NrOfChannels-1:0]          FallTick,
  output logic                             FPGA_Tick,
  output logic                             Busy
);

  localparam logic [NrOfBits-1:0] Reload =
    NrOfBits'(ReloadValue - 1);

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } phase_t;

  logic                    run_mode;
  logic                    step_mode;
  logic                    en;
  logic [NrOfBits-1:0]     pre_cnt;
  logic                    go_s1;
  logic                    go_s2;
  logic                    go_s3;
  logic                    go_rise;
  logic [NrOfChannels-1:0] fall_nxt;

  assign run_mode  = (Mode == 2'b01);
  assign step_mode = (Mode == 2'b10);
  assign en        = FPGA_Tick & (run_mode | (step_mode & Busy));
  assign go_rise   = go_s2 & ~go_s3;

  // Prescaler: free-running down-counter, one-cycle tick on wrap.
  always_ff @(posedge FPGA_GlobalClock or posedge RST) begin
    if (RST) begin
      pre_cnt   <= Reload;
      FPGA_Tick <= 1'b0;
    end else if (pre_cnt == '0) begin
      pre_cnt   <= Reload;
      FPGA_Tick <= 1'b1;
    end else begin
      pre_cnt   <= pre_cnt - 1'b1;
      FPGA_Tick <= 1'b0;
    end
  end

  // Go synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge FPGA_GlobalClock or posedge RST) begin
    if (RST) begin
      go_s1 <= 1'b0;
      go_s2 <= 1'b0;
      go_s3 <= 1'b0;
    end else begin
      go_s1 <= Go;
      go_s2 <= go_s1;
      go_s3 <= go_s2;
    end
  end

  // Step tracking; the final falling edge of channel 0 ends it,
  // and a Go edge arriving on that same edge is dropped.
  always_ff @(posedge FPGA_GlobalClock or posedge RST) begin
    if (RST) begin
      Busy <= 1'b0;
    end else if (!step_mode) begin
      Busy <= 1'b0;
    end else if (Busy) begin
      if (fall_nxt[0]) Busy <= 1'b0;
    end else if (go_rise) begin
      Busy <= 1'b1;
    end
  end

  function automatic logic [TickBits-1:0] load_val(
    input logic [TickBits-1:0] n
  );
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

  for (genvar i = 0; i < NrOfChannels; i++) begin : g_ch
    phase_t              phase;
    logic [TickBits-1:0] cnt;
    logic [TickBits-1:0] hi_n;
    logic [TickBits-1:0] lo_n;
    logic                wrap;
    logic                rise_q;
    logic                fall_q;

    assign hi_n        = HighTicks[i*TickBits +: TickBits];
    assign lo_n        = LowTicks[i*TickBits +: TickBits];
    assign wrap        = en && (cnt == '0);
    assign fall_nxt[i] = wrap && (phase == HIGH);
    assign ClkOut[i]   = (phase == HIGH);
    assign RiseTick[i] = rise_q;
    assign FallTick[i] = fall_q;

    // Phase FSM: count down enabled ticks, toggle and reload at 0.
    always_ff @(posedge FPGA_GlobalClock or posedge RST) begin
      if (RST) begin
        phase  <= LOW;
        cnt    <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (en) begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (phase == LOW) begin
            phase  <= HIGH;
            rise_q <= 1'b1;
            cnt    <= load_val(hi_n);
          end else begin
            phase  <= LOW;
            fall_q <= 1'b1;
            cnt    <= load_val(lo_n);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_logisim_clock_tree_gen.sv
// Randomised bench for logisim_clock_tree_gen against a
// tick-budget reference model.
module tb_logisim_clock_tree_gen;

  localparam int NCH = 2;
  localparam int TB  = 4;
  localparam int R   = 4;
  localparam int NB  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic [1:0]        mode;
  logic [NCH*TB-1:0] hi;
  logic [NCH*TB-1:0] lo;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    rise;
  logic [NCH-1:0]    fall;
  logic              tick;
  logic              busy;

  logisim_clock_tree_gen #(
    .NrOfChannels(NCH),
    .NrOfBits(NB),
    .ReloadValue(R),
    .TickBits(TB)
  ) dut (
    .FPGA_GlobalClock(clk),
    .RST(rst),
    .Go(go),
    .Mode(mode),
    .HighTicks(hi),
    .LowTicks(lo),
    .ClkOut(clk_out),
    .RiseTick(rise),
    .FallTick(fall),
    .FPGA_Tick(tick),
    .Busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: cycles since reset, ticks left per phase.
  int cyc_n;
  bit m_tick;
  bit m_busy;
  bit m_lvl  [NCH];
  int m_left [NCH];
  bit m_rise [NCH];
  bit m_fall [NCH];
  bit go_hist[4];

  task automatic model_reset();
    cyc_n  = 0;
    m_tick = 0;
    m_busy = 0;
    for (int i = 0; i < NCH; i++) begin
      m_lvl[i]  = 0;
      m_left[i] = 1;
      m_rise[i] = 0;
      m_fall[i] = 0;
    end
    for (int i = 0; i < 4; i++) go_hist[i] = 0;
  endtask

  task automatic model_step();
    bit en;
    bit go_edge;
    int n;
    for (int i = 3; i > 0; i--) go_hist[i] = go_hist[i-1];
    go_hist[0] = go;
    go_edge = go_hist[2] && !go_hist[3];
    en = m_tick && (mode == 2'b01 || (mode == 2'b10 && m_busy));
    for (int i = 0; i < NCH; i++) begin
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (en) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_lvl[i] = !m_lvl[i];
          if (m_lvl[i]) begin
            m_rise[i] = 1;
            n = hi[i*TB +: TB];
          end else begin
            m_fall[i] = 1;
            n = lo[i*TB +: TB];
          end
          m_left[i] = (n == 0) ? 1 : n;
        end
      end
    end
    if (mode != 2'b10) m_busy = 0;
    else if (m_busy) begin
      if (m_fall[0]) m_busy = 0;
    end else if (go_edge) m_busy = 1;
    cyc_n++;
    m_tick = (cyc_n % R == 0);
  endtask

  task automatic check_all(input string ph);
    logic [NCH-1:0] e_clk, e_rise, e_fall;
    for (int i = 0; i < NCH; i++) begin
      e_clk[i]  = m_lvl[i];
      e_rise[i] = m_rise[i];
      e_fall[i] = m_fall[i];
    end
    check({ph, ".tick"}, 32'(tick), 32'(m_tick));
    check({ph, ".clk"},  32'(clk_out), 32'(e_clk));
    check({ph, ".rise"}, 32'(rise), 32'(e_rise));
    check({ph, ".fall"}, 32'(fall), 32'(e_fall));
    check({ph, ".busy"}, 32'(busy), 32'(m_busy));
  endtask

  string phase_tag = "init";

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step();
    check_all(phase_tag);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all({phase_tag, ".rst_async"});
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic wait_lvl(input int ch, input bit v,
                          input int lim);
    int k = 0;
    while (m_lvl[ch] != v && k < lim) begin
      cyc();
      k++;
    end
    check({phase_tag, ".wait_lvl"}, 32'(k < lim), 32'd1);
  endtask

  task automatic wait_busy(input int lim);
    int k = 0;
    while (!m_busy && k < lim) begin
      cyc();
      k++;
    end
    check({phase_tag, ".wait_busy"}, 32'(k < lim), 32'd1);
  endtask

  initial begin
    int rises, falls;
    rst  = 1'b1;
    go   = 1'b0;
    mode = 2'b00;
    hi   = {4'd3, 4'd1};
    lo   = {4'd1, 4'd1};
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;

    phase_tag = "run";
    mode = 2'b01;
    repeat (48) cyc();

    phase_tag = "zero_ticks";
    hi = {4'd3, 4'd0};
    lo = {4'd1, 4'd0};
    wait_lvl(1, 1'b0, 64);
    wait_lvl(1, 1'b1, 64);
    repeat (2) cyc();
    hi = {4'd1, 4'd0};
    repeat (48) cyc();

    phase_tag = "step";
    hi = {4'd1, 4'd3};
    lo = {4'd1, 4'd1};
    pulse_reset();
    mode = 2'b10;
    repeat (10) cyc();
    rises = 0;
    falls = 0;
    go = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 10) go = 1'b0;
      if (k == 12) go = 1'b1;
      if (k == 20) go = 1'b0;
      cyc();
      rises += int'(rise[0]);
      falls += int'(fall[0]);
    end
    check("step.rises", 32'(rises), 32'd1);
    check("step.falls", 32'(falls), 32'd1);

    phase_tag = "halt";
    mode = 2'b01;
    wait_lvl(0, 1'b1, 64);
    repeat (2) cyc();
    mode = 2'b00;
    repeat (100) cyc();
    mode = 2'b01;
    repeat (40) cyc();

    phase_tag = "rst_step";
    mode = 2'b10;
    go   = 1'b0;
    repeat (4) cyc();
    go = 1'b1;
    wait_busy(16);
    cyc();
    pulse_reset();
    repeat (30) cyc();
    go = 1'b0;
    repeat (4) cyc();

    phase_tag = "rand";
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 9) == 0) pulse_reset();
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        hi = NCH*TB'($urandom_range(0, 255));
        lo = NCH*TB'($urandom_range(0, 255));
      end
      go = 1'($urandom_range(0, 1));
      repeat ($urandom_range(5, 40)) cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
